// File: rtl/ahb_dma_master_pkg.sv
// AHB-Lite transfer codes and DMA state encodings shared by the AHB master/slave
// blocks of this bus.
package ahb_dma_master_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RA   = 3'd1,
      ST_RD   = 3'd2,
      ST_WA   = 3'd3,
      ST_WD   = 3'd4,
      ST_FIN  = 3'd5
   } dma_state_e;

endpackage

// File: rtl/ahb_dma_master.sv
// Single-channel AHB-Lite DMA initiator: word-by-word read/write copy loop.
// Optional AHB_DMA_FIXED_DST_EN adds cfg_dst_fix to keep every write on one address.
module ahb_dma_master
   import ahb_dma_master_pkg::*;
#(
   parameter int         LEN_W     = 16,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             start,
   input  logic [31:0]      cfg_src,
   input  logic [31:0]      cfg_dst,
   input  logic [LEN_W-1:0] cfg_len,
`ifdef AHB_DMA_FIXED_DST_EN
   input  logic             cfg_dst_fix,
`endif
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic [2:0]       HSIZE,
   output logic [2:0]       HBURST,
   output logic [3:0]       HPROT,
   output logic             HMASTLOCK,
   output logic             HWRITE,
   output logic [31:0]      HWDATA,
   input  logic [31:0]      HRDATA,
   input  logic             HREADY,
   input  logic             HRESP
);

   dma_state_e       state, state_nx;
   logic [29:0]      src_ptr, dst_ptr;
   logic [LEN_W-1:0] remaining;
   logic [31:0]      rbuf;
   logic [31:0]      haddr_q;
   logic             hwrite_q;
   logic             dst_fix;
   logic             unused_addr_lsbs;

   assign unused_addr_lsbs = ^{cfg_src[1:0], cfg_dst[1:0]};

`ifdef AHB_DMA_FIXED_DST_EN
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)                   dst_fix <= 1'b0;
      else if (state == ST_IDLE && start) dst_fix <= cfg_dst_fix;
   end
`else
   assign dst_fix = 1'b0;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= ST_IDLE;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         rbuf      <= '0;
         err       <= 1'b0;
         haddr_q   <= '0;
         hwrite_q  <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: if (start) begin
               src_ptr   <= cfg_src[31:2];
               dst_ptr   <= cfg_dst[31:2];
               remaining <= cfg_len;
               err       <= 1'b0;
            end
            ST_RD: if (HREADY) begin
               if (HRESP) err  <= 1'b1;
               else       rbuf <= HRDATA;
            end
            ST_WD: if (HREADY) begin
               if (HRESP) err <= 1'b1;
               else begin
                  src_ptr   <= src_ptr + 30'd1;
                  if (!dst_fix) dst_ptr <= dst_ptr + 30'd1;
                  remaining <= remaining - LEN_W'(1);
               end
            end
            default: ;
         endcase
         // Address/direction are held between address phases; only HTRANS flags validity.
         if (state == ST_RA || state == ST_WA) begin
            haddr_q  <= HADDR;
            hwrite_q <= HWRITE;
         end
      end
   end

   always_comb begin
      state_nx = state;
      HTRANS   = HTRANS_IDLE;
      HADDR    = haddr_q;
      HWRITE   = hwrite_q;
      case (state)
         ST_IDLE: if (start) state_nx = (cfg_len == '0) ? ST_FIN : ST_RA;
         ST_RA: begin
            HTRANS = HTRANS_NONSEQ;
            HADDR  = {src_ptr, 2'b00};
            HWRITE = 1'b0;
            if (HREADY) state_nx = ST_RD;
         end
         ST_RD: if (HREADY) state_nx = HRESP ? ST_FIN : ST_WA;
         ST_WA: begin
            HTRANS = HTRANS_NONSEQ;
            HADDR  = {dst_ptr, 2'b00};
            HWRITE = 1'b1;
            if (HREADY) state_nx = ST_WD;
         end
         ST_WD: if (HREADY) state_nx = (HRESP || remaining == LEN_W'(1)) ? ST_FIN : ST_RA;
         ST_FIN:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   assign busy      = (state == ST_RA) || (state == ST_RD) || (state == ST_WA) || (state == ST_WD);
   assign done      = (state == ST_FIN);
   assign HWDATA    = rbuf;
   assign HSIZE     = HSIZE_WORD;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_dma_master.sv
// Scoreboard bench for ahb_dma_master: a memory-backed AHB slave with random waits
// and error injection, checked against a sequential word-copy reference model.
`timescale 1ns/1ps
module tb_ahb_dma_master;

   localparam int LEN_W = 16;

   logic HCLK = 1'b0, HRESETn = 1'b0, start = 1'b0;
   logic [31:0] cfg_src = '0, cfg_dst = '0;
   logic [LEN_W-1:0] cfg_len = '0;
`ifdef AHB_DMA_FIXED_DST_EN
   logic cfg_dst_fix = 1'b0;
`endif
   logic busy, done, err, HMASTLOCK, HWRITE;
   logic [31:0] HADDR, HWDATA;
   logic [31:0] HRDATA = '0;
   logic [1:0] HTRANS;
   logic [2:0] HSIZE, HBURST;
   logic [3:0] HPROT;
   logic HREADY = 1'b1, HRESP = 1'b0;

   ahb_dma_master #(.LEN_W(LEN_W)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
      .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
`ifdef AHB_DMA_FIXED_DST_EN
      .cfg_dst_fix(cfg_dst_fix),
`endif
      .busy(busy), .done(done), .err(err),
      .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;

   typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } txn_t;
   typedef struct { logic err; int cycles; } cmp_t;

   txn_t exp_q[$];
   cmp_t done_q[$];
   logic [31:0] smem [logic [29:0]];
   logic [31:0] rmem [logic [29:0]];
   logic [31:0] pat [4];

   int errors = 0, checks = 0;
   int cyc = 0, start_cyc = 0, done_cnt = 0;
   int wait_mode = 0, err_txn = -1, txn_cnt = 0;

   // slave state
   bit dp_act = 0, dp_wr = 0, dp_err = 0, aw_on = 0, err_ph = 0;
   logic [29:0] dp_addr = '0;
   logic [31:0] dp_exp = '0;
   int dp_wait = 0, aw_cnt = 0;
   logic hready_d = 1'b1, hwrite_d = 1'b0;
   logic [1:0] htrans_d = 2'b00;
   logic [31:0] haddr_d = '0, hwdata_d = '0;

   function automatic logic [31:0] fill(input logic [29:0] a);
      return {a[27:0], 4'h5} ^ 32'hC3A5_0F1E;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event not expected at cycle %0d", name, cyc);
   endtask

   always @(posedge HCLK) cyc <= cyc + 1;

   // Slave + monitor: every edge-dependent observation happens at the negedge.
   always @(negedge HCLK) begin
      txn_t x;
      cmp_t c;
      if (!HRESETn) begin
         dp_act = 0; aw_on = 0; hready_d = 1'b1; htrans_d = 2'b00;
         HREADY = 1'b1; HRESP = 1'b0;
      end else begin
         if (start) txn_cnt = 0;
         if (hready_d && dp_act) begin
            if (dp_wr) begin
               chk("wdata", hwdata_d, dp_exp);
               if (!dp_err) smem[dp_addr] = hwdata_d;
            end
            dp_act = 0;
         end
         if (hready_d && htrans_d == 2'b10) begin
            if (exp_q.size() == 0) flag("unexpected_txn");
            else begin
               x = exp_q.pop_front();
               chk("haddr", haddr_d, x.addr);
               chk("hwrite", {31'd0, hwrite_d}, {31'd0, x.wr});
               dp_exp = x.data;
            end
            dp_act = 1; dp_addr = haddr_d[31:2]; dp_wr = hwrite_d;
            dp_err = (txn_cnt == err_txn); txn_cnt++; err_ph = 0;
            dp_wait = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
         end
         if (!hready_d && htrans_d == 2'b10) begin
            chk("haddr_stable", HADDR, haddr_d);
            chk("htrans_stable", {30'd0, HTRANS}, {30'd0, htrans_d});
         end
         if (!hready_d && dp_act && dp_wr) chk("hwdata_stable", HWDATA, hwdata_d);
         if (done) begin
            done_cnt++;
            if (done_q.size() == 0) flag("unexpected_done");
            else begin
               c = done_q.pop_front();
               chk("err_at_done", {31'd0, err}, {31'd0, c.err});
               chk("busy_at_done", {31'd0, busy}, 32'd0);
               chk("txns_left", exp_q.size(), 32'd0);
               if (c.cycles >= 0) chk("done_latency", cyc - start_cyc, c.cycles);
            end
         end
         // drive the slave response for the coming edge
         HRDATA = 32'hDEAD_BEEF; HRESP = 1'b0; HREADY = 1'b1;
         if (dp_act) begin
            if (dp_wait > 0) begin
               HREADY = 1'b0; dp_wait--;
            end else if (dp_err && !err_ph) begin
               HREADY = 1'b0; HRESP = 1'b1; err_ph = 1;
            end else begin
               HRESP = dp_err;
               if (!dp_wr) HRDATA = smem.exists(dp_addr) ? smem[dp_addr] : fill(dp_addr);
            end
         end else if (HTRANS == 2'b10) begin
            if (!aw_on) begin
               aw_on = 1;
               aw_cnt = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
            end
            if (aw_cnt > 0) begin HREADY = 1'b0; aw_cnt--; end
            else aw_on = 0;
         end
         hready_d = HREADY; htrans_d = HTRANS; haddr_d = HADDR;
         hwrite_d = HWRITE; hwdata_d = HWDATA;
      end
   end

   // Reference: sequential word copy on a flat memory; an erroring transfer ends the job.
   task automatic model(input logic [31:0] src, input logic [31:0] dst, input int len,
                        input bit fix, input int err_at, input int wmode);
      logic [29:0] s, d;
      logic [31:0] v;
      int t;
      bit e;
      txn_t x;
      cmp_t c;
      s = src[31:2]; d = dst[31:2]; t = 0; e = 0;
      for (int i = 0; i < len; i++) begin
         x.wr = 1'b0; x.addr = {s, 2'b00}; x.data = '0;
         exp_q.push_back(x);
         if (t == err_at) begin e = 1; break; end
         t++;
         v = rmem.exists(s) ? rmem[s] : fill(s);
         x.wr = 1'b1; x.addr = {d, 2'b00}; x.data = v;
         exp_q.push_back(x);
         if (t == err_at) begin e = 1; break; end
         t++;
         rmem[d] = v;
         s = s + 30'd1;
         if (!fix) d = d + 30'd1;
      end
      c.err = e;
      c.cycles = (wmode >= 0 && !e) ? 1 + len * 4 * (wmode + 1) : -1;
      done_q.push_back(c);
   endtask

   task automatic kick(input logic [31:0] src, input logic [31:0] dst, input int len,
                       input bit fix, input int err_at, input int wmode);
      @(negedge HCLK); #1;
      wait_mode = wmode; err_txn = err_at;
      model(src, dst, len, fix, err_at, wmode);
      cfg_src = src; cfg_dst = dst; cfg_len = LEN_W'(len);
`ifdef AHB_DMA_FIXED_DST_EN
      cfg_dst_fix = fix;
`endif
      start = 1'b1; start_cyc = cyc;
      @(negedge HCLK); #1;
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, {31'd0, len != 0});
      chk("err_cleared_by_start", {31'd0, err}, 32'd0);
   endtask

   task automatic run(input logic [31:0] src, input logic [31:0] dst, input int len,
                      input bit fix, input int err_at, input int wmode, input bit disturb);
      int n, k;
      n = done_cnt;
      kick(src, dst, len, fix, err_at, wmode);
      k = 0;
      while (done_cnt == n && k < 2000) begin
         @(negedge HCLK); #1;
         if (disturb && k == 3) begin
            cfg_src = 32'h1234_5670; cfg_dst = 32'h0BAD_0000; cfg_len = LEN_W'(9); start = 1'b1;
         end
         if (disturb && k == 4) start = 1'b0;
         k++;
      end
      if (done_cnt == n) flag("done_timeout");
   endtask

   initial begin
      int len, err_at, wm;
      logic [31:0] s, d;
      pat[0] = 32'h1111_1111; pat[1] = 32'h2222_2222;
      pat[2] = 32'h3333_3333; pat[3] = 32'h4444_4444;

      #1;
      chk("rst_haddr", HADDR, 32'd0);
      chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
      chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
      chk("rst_hwdata", HWDATA, 32'd0);
      chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
      chk("const_ctrl", {20'd0, HSIZE, HBURST, HPROT, 1'b0, HMASTLOCK}, {20'd0, 3'b010, 3'b000, 4'b0011, 1'b0, 1'b0});
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;

      // zero-wait copy of a known pattern
      for (int i = 0; i < 4; i++) begin
         smem[30'h0800_0000 + 30'(i)] = pat[i];
         rmem[30'h0800_0000 + 30'(i)] = pat[i];
      end
      run(32'h2000_0000, 32'h2000_0100, 4, 0, -1, 0, 0);
      for (int i = 0; i < 4; i++) chk("copy_pattern", smem[30'h0800_0040 + 30'(i)], pat[i]);

      // two wait states in every phase
      run(32'h2000_0000, 32'h2000_0200, 2, 0, -1, 2, 0);

      // second read errors: one write only, sticky err, next start clears it
      run(32'h2000_0000, 32'h2000_0303, 3, 0, 2, 0, 0);
      @(negedge HCLK); #1;
      chk("err_sticky", {31'd0, err}, 32'd1);
      run(32'h2000_0010, 32'h2000_0400, 1, 0, -1, 0, 0);

      // zero length
      run(32'h2000_0000, 32'h2000_0500, 0, 0, -1, 0, 0);

      // start while busy is ignored
      run(32'h2000_0001, 32'h2000_0602, 3, 0, -1, 1, 1);

      // randomized transfers
      for (int r = 0; r < 10; r++) begin
         len = int'($urandom_range(1, 5));
         s = $urandom; d = $urandom;
         wm = int'($urandom_range(0, 3)) - 1;
         err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * len - 1)) : -1;
         run(s, d, len, 0, err_at, wm, 0);
      end
      run(32'hFFFF_FFF8, 32'h0000_0FF0, 4, 0, -1, 0, 0);

`ifdef AHB_DMA_FIXED_DST_EN
      run(32'h2000_0000, 32'h4000_0000, 3, 1, -1, 0, 0);
`endif

      foreach (rmem[a]) chk("final_mem", smem.exists(a) ? smem[a] : fill(a), rmem[a]);

      // reset in the middle of a write address phase
      kick(32'h2000_0000, 32'h2000_0700, 4, 0, -1, 1);
      for (int k = 0; k < 200 && !(HTRANS == 2'b10 && HWRITE); k++) begin
         @(negedge HCLK); #1;
      end
      chk("reached_wa", {30'd0, HTRANS, HWRITE}, {30'd0, 2'b10, 1'b1});
      #1 HRESETn = 1'b0;
      #1;
      chk("rst_mid_htrans", {30'd0, HTRANS}, 32'd0);
      chk("rst_mid_flags", {29'd0, busy, done, err}, 32'd0);
      chk("rst_mid_haddr", HADDR, 32'd0);
      exp_q.delete();
      done_q.delete();
      for (int k = 0; k < 3; k++) begin
         @(negedge HCLK); #1;
         chk("no_done_in_reset", {31'd0, done}, 32'd0);
      end
      HRESETn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge HCLK); #1;
         chk("idle_after_reset", {29'd0, HTRANS, done}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
